reorder_buffer: RTL

//  Circular in-order reorder buffer between issue/CDB and the register file. Allocates ROB tags at

---
 rtl/reorder_buffer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags 1..2^ROB_LOG-1 at issue, captures CDB results,
// retires the head in program order and flushes on a mispredicted branch. Option: ROB_CDB_BYPASS_EN.
module reorder_buffer #(
   parameter int ROB_LOG = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               issue_valid,
   input  logic               issue_has_dest,
   input  logic [4:0]         issue_dest,
   input  logic               issue_is_branch,
   input  logic [31:0]        issue_pred_pc,
   output logic [ROB_LOG-1:0] issue_reorder,
   output logic               rob_full,
   input  logic               cdb_valid,
   input  logic [ROB_LOG-1:0] cdb_reorder,
   input  logic [31:0]        cdb_value,
   input  logic [31:0]        cdb_next_pc,
   input  logic [ROB_LOG-1:0] query_j_reorder,
   output logic               query_j_ready,
   output logic [31:0]        query_j_value,
   input  logic [ROB_LOG-1:0] query_k_reorder,
   output logic               query_k_ready,
   output logic [31:0]        query_k_value,
   output logic               commit_valid,
   output logic [4:0]         commit_dest,
   output logic [31:0]        commit_value,
   output logic [ROB_LOG-1:0] commit_reorder,
   output logic               rob_flush,
   output logic [31:0]        flush_pc
);

   localparam int DEPTH = 2 ** ROB_LOG;
   localparam logic [ROB_LOG-1:0] PTR_ONE = ROB_LOG'(1);
   localparam logic [ROB_LOG-1:0] PTR_MAX = '1;

   typedef struct packed {
      logic        busy;
      logic        ready;
      logic        has_dest;
      logic [4:0]  dest;
      logic        is_branch;
      logic [31:0] pred_pc;
      logic [31:0] value;
      logic [31:0] next_pc;
   } entry_t;

   // Slot 0 is never allocated, so the count never exceeds PTR_MAX and fits in ROB_LOG bits.
   entry_t             rob_q [DEPTH];
   entry_t             rob_d [DEPTH];
   logic [ROB_LOG-1:0] head_q, head_d;
   logic [ROB_LOG-1:0] tail_q, tail_d;
   logic [ROB_LOG-1:0] count_q, count_d;

   logic               commit_valid_q, commit_valid_d;
   logic [4:0]         commit_dest_q, commit_dest_d;
   logic [31:0]        commit_value_q, commit_value_d;
   logic [ROB_LOG-1:0] commit_reorder_q, commit_reorder_d;
   logic               rob_flush_q, rob_flush_d;
   logic [31:0]        flush_pc_q, flush_pc_d;

   entry_t head_entry;
   logic   do_commit;
   logic   do_issue;
   logic   mispredict;

   function automatic logic [ROB_LOG-1:0] next_ptr(input logic [ROB_LOG-1:0] p);
      return (p == PTR_MAX) ? PTR_ONE : p + PTR_ONE;
   endfunction

   assign head_entry    = rob_q[head_q];
   assign rob_full      = (count_q == PTR_MAX);
   assign issue_reorder = tail_q;
   assign do_commit     = (count_q != '0) && head_entry.busy && head_entry.ready;
   assign do_issue      = issue_valid && !rob_full;
   assign mispredict    = do_commit && head_entry.is_branch &&
                          (head_entry.next_pc != head_entry.pred_pc);

   // NOTE: combinational next-state uses blocking '=' with every output defaulted first, so no latch is inferred.
   always_comb begin
      rob_d            = rob_q;
      head_d           = head_q;
      tail_d           = tail_q;
      count_d          = count_q;
      commit_valid_d   = 1'b0;
      commit_dest_d    = commit_dest_q;
      commit_value_d   = commit_value_q;
      commit_reorder_d = commit_reorder_q;
      rob_flush_d      = 1'b0;
      flush_pc_d       = '0;

      if (rdy) begin
         if (do_commit) begin
            commit_valid_d   = head_entry.has_dest;
            commit_dest_d    = head_entry.dest;
            commit_value_d   = head_entry.value;
            commit_reorder_d = head_q;
         end

         if (mispredict) begin
            // The mispredicted branch retires, then every younger entry is discarded.
            rob_flush_d = 1'b1;
            flush_pc_d  = head_entry.next_pc;
            for (int i = 0; i < DEPTH; i++) begin
               rob_d[i].busy  = 1'b0;
               rob_d[i].ready = 1'b0;
            end
            head_d  = PTR_ONE;
            tail_d  = PTR_ONE;
            count_d = '0;
         end else begin
            if (cdb_valid && rob_q[cdb_reorder].busy) begin
               rob_d[cdb_reorder].ready   = 1'b1;
               rob_d[cdb_reorder].value   = cdb_value;
               rob_d[cdb_reorder].next_pc = cdb_next_pc;
            end

            if (do_commit) begin
               rob_d[head_q].busy  = 1'b0;
               rob_d[head_q].ready = 1'b0;
               head_d              = next_ptr(head_q);
            end

            if (do_issue) begin
               rob_d[tail_q].busy      = 1'b1;
               rob_d[tail_q].ready     = 1'b0;
               rob_d[tail_q].has_dest  = issue_has_dest;
               rob_d[tail_q].dest      = issue_dest;
               rob_d[tail_q].is_branch = issue_is_branch;
               rob_d[tail_q].pred_pc   = issue_pred_pc;
               tail_d                  = next_ptr(tail_q);
            end

            if (do_issue && !do_commit) begin
               count_d = count_q + PTR_ONE;
            end else if (!do_issue && do_commit) begin
               count_d = count_q - PTR_ONE;
            end
         end
      end
   end

   // NOTE: the entry array is a small flop bank, so it is reset in full; stale data then never reads as X.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            rob_q[i] <= '0;
         end
         head_q           <= PTR_ONE;
         tail_q           <= PTR_ONE;
         count_q          <= '0;
         commit_valid_q   <= 1'b0;
         commit_dest_q    <= '0;
         commit_value_q   <= '0;
         commit_reorder_q <= '0;
         rob_flush_q      <= 1'b0;
         flush_pc_q       <= '0;
      end else begin
         rob_q            <= rob_d;
         head_q           <= head_d;
         tail_q           <= tail_d;
         count_q          <= count_d;
         commit_valid_q   <= commit_valid_d;
         commit_dest_q    <= commit_dest_d;
         commit_value_q   <= commit_value_d;
         commit_reorder_q <= commit_reorder_d;
         rob_flush_q      <= rob_flush_d;
         flush_pc_q       <= flush_pc_d;
      end
   end

   assign commit_valid   = commit_valid_q;
   assign commit_dest    = commit_dest_q;
   assign commit_value   = commit_value_q;
   assign commit_reorder = commit_reorder_q;
   assign rob_flush      = rob_flush_q;
   assign flush_pc       = flush_pc_q;

   // Operand lookups; slot 0 is never busy, so tag 0 always reads as not ready.
   always_comb begin
      query_j_ready = rob_q[query_j_reorder].busy && rob_q[query_j_reorder].ready;
      query_j_value = (query_j_reorder == '0) ? '0 : rob_q[query_j_reorder].value;
      query_k_ready = rob_q[query_k_reorder].busy && rob_q[query_k_reorder].ready;
      query_k_value = (query_k_reorder == '0) ? '0 : rob_q[query_k_reorder].value;
`ifdef ROB_CDB_BYPASS_EN
      if (cdb_valid && (cdb_reorder == query_j_reorder) && rob_q[query_j_reorder].busy) begin
         query_j_ready = 1'b1;
         query_j_value = cdb_value;
      end
      if (cdb_valid && (cdb_reorder == query_k_reorder) && rob_q[query_k_reorder].busy) begin
         query_k_ready = 1'b1;
         query_k_value = cdb_value;
      end
`else
      // Without bypass a broadcast becomes visible to queries only after it is captured.
`endif
   end

endmodule
